// File: rtl/pcle_cnt_seq_if.sv
// pcle_cnt_seq_if: control/status bundle of the cascadable counter cell.
// master drives the controls, slave is the counter itself.
interface pcle_cnt_seq_if #(
  parameter int WIDTH = 8
);
  logic             load_pad;
  logic [WIDTH-1:0] data_pad;
  logic             cnt_en_pad;
  logic             inhibit_pad;
  logic             carry_in_pad;
  logic             up_pad;
  logic             clr_wrap_pad;
  logic [WIDTH-1:0] count_pad;
  logic             tc_pad;
  logic             carry_out_pad;
  logic             wrap_pad;

  modport master (
    output load_pad,
    output data_pad,
    output cnt_en_pad,
    output inhibit_pad,
    output carry_in_pad,
    output up_pad,
    output clr_wrap_pad,
    input  count_pad,
    input  tc_pad,
    input  carry_out_pad,
    input  wrap_pad
  );

  modport slave (
    input  load_pad,
    input  data_pad,
    input  cnt_en_pad,
    input  inhibit_pad,
    input  carry_in_pad,
    input  up_pad,
    input  clr_wrap_pad,
    output count_pad,
    output tc_pad,
    output carry_out_pad,
    output wrap_pad
  );
endinterface

// File: rtl/pcle_cnt_seq.sv
// pcle_cnt_seq: loadable, cascadable up/down counter with programmable modulus.
// Define PCLE_CNT_SATURATE_EN to hold at the terminal value instead of wrapping.
module pcle_cnt_seq #(
  parameter int          WIDTH     = 8,
  parameter int unsigned MAX_COUNT = 2**WIDTH-1
) (
  input logic           clk_pad,
  input logic           rst_n_pad,
  pcle_cnt_seq_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V = MAX_COUNT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] wrap_val;
  logic [WIDTH-1:0] step_val;
  logic             wrap_q;
  logic             wrap_d;
  logic             active;
  logic             at_term;
  logic             wrap_evt;
  logic             step;

  assign active = bus.cnt_en_pad
                & ~bus.inhibit_pad
                & bus.carry_in_pad
                & ~bus.load_pad;

  assign term     = bus.up_pad ? MAX_V : '0;
  assign at_term  = (count_q == term);
  assign wrap_evt = active & at_term;
  assign step     = active & ~at_term;

  assign load_val = (bus.data_pad > MAX_V)
                  ? MAX_V
                  : bus.data_pad;

  assign step_val = bus.up_pad
                  ? count_q + ONE
                  : count_q - ONE;

`ifdef PCLE_CNT_SATURATE_EN
  assign wrap_val = count_q;
`else
  assign wrap_val = bus.up_pad ? '0 : MAX_V;
`endif

  // wrap event beats clr_wrap on the same edge
  always_comb begin
    count_d = count_q;
    wrap_d  = wrap_q;
    unique case (1'b1)
      bus.load_pad: begin
        count_d = load_val;
        wrap_d  = 1'b0;
      end
      wrap_evt: begin
        count_d = wrap_val;
        wrap_d  = 1'b1;
      end
      step: begin
        count_d = step_val;
        wrap_d  = wrap_q & ~bus.clr_wrap_pad;
      end
      default: begin
        wrap_d  = wrap_q & ~bus.clr_wrap_pad;
      end
    endcase
  end

  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count_pad     = count_q;
  assign bus.tc_pad        = at_term;
  assign bus.carry_out_pad = at_term & active;
  assign bus.wrap_pad      = wrap_q;

endmodule
